// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the FSM state encoding and the default register-file geometry.
package reg_wb_arbiter_pkg;

    localparam int DEF_ADW = 5;
    localparam int DEF_DPW = 32;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        STALLED = 2'd2
    } wb_state_e;

    // Round-robin pointer successor: index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr.sv
// Round-robin selector: first asserted request at or after ptr_i, wrapping modulo N.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o
);

    int   raw_s;
    int   idx_s;
    logic hit_s;
    logic found_s;

    // Scan N positions starting at the pointer and keep only the first hit.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        raw_s     = 0;
        idx_s     = 0;
        for (int k = 0; k < N; k++) begin
            raw_s         = int'(ptr_i) + k;
            idx_s         = (raw_s >= N) ? raw_s - N : raw_s;
            hit_s         = !found_s && req_i[idx_s];
            found_s       = found_s | hit_s;
            gnt_o[idx_s]  = hit_s;
            gnt_idx_o     = hit_s ? PW'(idx_s) : gnt_idx_o;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: picks one of NREQ requesters round-robin, holds the winner in a
// one-entry register and drives the register-file write port one cycle later.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADW  = DEF_ADW,
    parameter int DPW  = DEF_DPW,
    parameter int NREQ = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0][ADW-1:0]  req_addr,
    input  logic [NREQ-1:0][DPW-1:0]  req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wb_stall,
    input  logic                      wb_flush,
    output logic                      we_3,
    output logic [ADW-1:0]            addr_3,
    output logic [DPW-1:0]            wd_3,
    output logic [CNT_W-1:0]          wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_state_e         state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [ADW-1:0]    addr_q, addr_d;
    logic [DPW-1:0]    data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   gnt_s;
    logic [PW-1:0]     gnt_idx_s;
    logic              block_s;
    logic              accept_s;
    logic              we_s;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s)
    );

    // Accept gating and write-enable qualification.
    // The write is suppressed in the very cycle a stall, flush or reset shows up,
    // so a held or discarded entry never reaches the register file twice or at all.
    always_comb begin
        block_s   = rst | wb_stall | wb_flush | (state_q == STALLED);
        req_ready = block_s ? '0 : gnt_s;
        accept_s  = |req_ready;
        we_s      = (state_q == WRITE) && (addr_q != '0) &&
                    !wb_stall && !wb_flush && !rst;
    end

    // Next-state for FSM, pointer, capture register and write counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        if (accept_s) begin
            ptr_d  = PW'(wrap_inc(int'(gnt_idx_s), NREQ));
            addr_d = req_addr[gnt_idx_s];
            data_d = req_data[gnt_idx_s];
        end else begin
            ptr_d  = ptr_q;
            addr_d = addr_q;
            data_d = data_q;
        end

        if (we_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wb_stall) begin
                    state_d = STALLED;
                end else if (accept_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            STALLED: begin
                if (wb_stall) begin
                    state_d = STALLED;
                end else begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wb_flush) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign we_3     = we_s;
    assign addr_3   = addr_q;
    assign wd_3     = data_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_reg_wb_arbiter;

    localparam int ADW  = 5;
    localparam int DPW  = 32;
    localparam int NREQ = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      wb_stall;
    logic                      wb_flush;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][ADW-1:0]  req_addr;
    logic [NREQ-1:0][DPW-1:0]  req_data;
    logic                      we_3;
    logic [ADW-1:0]            addr_3;
    logic [DPW-1:0]            wd_3;
    logic [15:0]               wr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: pointer, pending entry, held flag, commit count.
    int          m_ptr  = 0;
    bit          m_pend = 1'b0;
    bit          m_held = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_data = 32'd0;
    int          m_cnt  = 0;

    logic [NREQ-1:0][ADW-1:0] aa;
    logic [NREQ-1:0][DPW-1:0] dd;
    logic [NREQ-1:0]          o_rdy;
    logic                     o_we;
    logic [2:0]               exp_order [6];

    reg_wb_arbiter #(.ADW(ADW), .DPW(DPW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_stall  (wb_stall),
        .wb_flush  (wb_flush),
        .we_3      (we_3),
        .addr_3    (addr_3),
        .wd_3      (wd_3),
        .wr_count  (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0][ADW-1:0] a,
                        input logic [NREQ-1:0][DPW-1:0] d, input logic s, input logic f,
                        input logic r, output logic [NREQ-1:0] rdy_o, output logic we_o);
        logic [NREQ-1:0] e_rdy;
        bit              e_we;
        int              g;
        int              j;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        wb_stall  = s;
        wb_flush  = f;
        rst       = r;
        @(negedge clk);
        e_rdy = '0;
        g     = -1;
        if (!(r || s || f || m_held)) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (g < 0 && v[j]) g = j;
            end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        e_we = m_pend && !m_held && !s && !f && !r && (m_addr != 0);
        chk("ready", 32'(req_ready), 32'(e_rdy));
        chk("we_3", 32'(we_3), 32'(e_we));
        chk("addr_3", 32'(addr_3), 32'(m_addr));
        chk("wd_3", wd_3, m_data);
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        rdy_o = req_ready;
        we_o  = we_3;
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_pend = 1'b0; m_held = 1'b0;
            m_addr = 0; m_data = 32'd0; m_cnt = 0;
        end else begin
            if (e_we) m_cnt = (m_cnt + 1) % 65536;
            if (f) begin
                m_pend = 1'b0;
                m_held = 1'b0;
            end else if (s) begin
                m_held = m_pend;
            end else if (m_held) begin
                m_held = 1'b0;
            end else if (g >= 0) begin
                m_pend = 1'b1;
                m_addr = int'(a[g]);
                m_data = d[g];
                m_ptr  = (g + 1) % NREQ;
            end else begin
                m_pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_cycle(input logic s, input logic f, input logic r);
        step('0, aa, dd, s, f, r, o_rdy, o_we);
    endtask

    initial begin
        rst = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        aa = '0; dd = '0;
        @(posedge clk);
        #1;

        // Reset holds everything quiet even with all requesters valid.
        step(3'b111, aa, dd, 1'b0, 1'b0, 1'b1, o_rdy, o_we);
        chk("rst_ready", 32'(o_rdy), 32'd0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_cnt", 32'(wr_count), 32'd0);

        // Single request, one-cycle latency.
        aa = '0; dd = '0; aa[0] = 5'd5; dd[0] = 32'hDEADBEEF;
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        chk("single_ready", 32'(o_rdy), 32'd1);
        idle_cycle(1'b0, 1'b0, 1'b0);
        chk("single_we", 32'(o_we), 32'd1);
        chk("single_addr", 32'(addr_3), 32'd5);
        chk("single_data", wd_3, 32'hDEADBEEF);
        chk("single_cnt", 32'(wr_count), 32'd1);

        // Sustained requests from all: strict rotation.
        idle_cycle(1'b0, 1'b0, 1'b1);
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        aa[0] = 5'd1; aa[1] = 5'd2; aa[2] = 5'd3;
        for (int i = 0; i < 6; i++) begin
            dd[0] = $urandom; dd[1] = $urandom; dd[2] = $urandom;
            step(3'b111, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
            chk("rr_order", 32'(o_rdy), 32'(exp_order[i]));
        end
        idle_cycle(1'b0, 1'b0, 1'b0);
        chk("rr_cnt", 32'(wr_count), 32'd6);

        // Write to x0 is accepted but dropped.
        idle_cycle(1'b0, 1'b0, 1'b1);
        aa = '0; dd = '0; dd[0] = 32'h1234;
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        chk("x0_ready", 32'(o_rdy), 32'd1);
        idle_cycle(1'b0, 1'b0, 1'b0);
        chk("x0_we", 32'(o_we), 32'd0);
        chk("x0_cnt", 32'(wr_count), 32'd0);

        // Stall holds the entry; release produces exactly one write.
        idle_cycle(1'b0, 1'b0, 1'b1);
        aa = '0; dd = '0; aa[0] = 5'd7; dd[0] = 32'hA5;
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        for (int i = 0; i < 3; i++) begin
            step(3'b111, aa, dd, 1'b1, 1'b0, 1'b0, o_rdy, o_we);
            chk("stall_we", 32'(o_we), 32'd0);
            chk("stall_ready", 32'(o_rdy), 32'd0);
            chk("stall_addr", 32'(addr_3), 32'd7);
        end
        idle_cycle(1'b0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0);
        chk("release_we", 32'(o_we), 32'd1);
        chk("release_data", wd_3, 32'hA5);
        idle_cycle(1'b0, 1'b0, 1'b0);
        chk("release_once", 32'(o_we), 32'd0);
        chk("release_cnt", 32'(wr_count), 32'd1);

        // Flush beats stall: entry discarded, block returns to idle.
        idle_cycle(1'b0, 1'b0, 1'b1);
        aa = '0; aa[0] = 5'd9; dd[0] = 32'h99;
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        step(3'b111, aa, dd, 1'b1, 1'b1, 1'b0, o_rdy, o_we);
        chk("flush_we", 32'(o_we), 32'd0);
        chk("flush_ready", 32'(o_rdy), 32'd0);
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        chk("flush_after_we", 32'(o_we), 32'd0);
        chk("flush_idle_ready", 32'(o_rdy), 32'd1);
        chk("flush_cnt", 32'(wr_count), 32'd0);
        idle_cycle(1'b0, 1'b0, 1'b0);

        // Reset right after an accept kills the pending write and rewinds the pointer.
        idle_cycle(1'b0, 1'b0, 1'b1);
        aa = '0; aa[0] = 5'd3; dd[0] = 32'h33;
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        idle_cycle(1'b0, 1'b0, 1'b1);
        chk("rst_mid_we", 32'(o_we), 32'd0);
        aa[1] = 5'd4; aa[2] = 5'd6;
        step(3'b111, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        chk("rst_mid_we2", 32'(o_we), 32'd0);
        chk("rst_mid_ptr", 32'(o_rdy), 32'd1);
        chk("rst_mid_cnt", 32'(wr_count), 32'd0);

        // Randomized traffic with stalls, flushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [NREQ-1:0] v;
            logic s, f, r;
            v = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                aa[k] = ADW'($urandom_range(0, 31));
                dd[k] = $urandom;
            end
            s = ($urandom_range(0, 99) < 20);
            f = ($urandom_range(0, 99) < 7);
            r = ($urandom_range(0, 99) < 2);
            step(v, aa, dd, s, f, r, o_rdy, o_we);
        end

        // Counter wrap: sustained writes until 0xFFFF, then one more.
        idle_cycle(1'b0, 1'b0, 1'b1);
        aa = '0; aa[0] = 5'd1;
        for (int i = 0; i < 65536; i++) begin
            dd[0] = $urandom;
            step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        end
        chk("wrap_pre", 32'(wr_count), 32'h0000FFFF);
        step(3'b001, aa, dd, 1'b0, 1'b0, 1'b0, o_rdy, o_we);
        chk("wrap_zero", 32'(wr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
